// File: rtl/a2d_pkg.sv
// Shared types and constants for the round-robin ADC interface and its SPI master.
// Channel decode and command-word helpers live here so the FSM stays small.
package a2d_pkg;

  typedef enum logic [2:0] {IDLE, XFR1, GAP, XFR2, DONE} a2d_state_t;
  typedef enum logic [1:0] {SP_IDLE, SP_SHIFT, SP_BACK} spi_phase_t;

  localparam logic [2:0] CH_LFT  = 3'd0;
  localparam logic [2:0] CH_RGHT = 3'd4;
  localparam logic [2:0] CH_BATT = 3'd5;

  // robin value 3 is unreachable; it decodes like 0
  function automatic logic [2:0] robin_chnl(input logic [1:0] r);
    case (r)
      2'd1:    return CH_RGHT;
      2'd2:    return CH_BATT;
      default: return CH_LFT;
    endcase
  endfunction

  function automatic logic [1:0] robin_next(input logic [1:0] r);
    case (r)
      2'd1:    return 2'd2;
      2'd2:    return 2'd0;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [15:0] cmd_word(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/spi_mnrch.sv
// Generic 16-bit SPI master: SCLK idles high, MOSI changes after each fall, MISO sampled on each rise.
// One down-counter times both the SS_n porches and the SCLK half-periods.
import a2d_pkg::*;

module spi_mnrch #(
  parameter int SCLK_DIV = 16,
  parameter int PORCH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int HALF = SCLK_DIV / 2;
  localparam int TMAX = (PORCH > HALF) ? PORCH : HALF;
  localparam int TW   = $clog2(TMAX + 1);

  spi_phase_t     ph;
  logic [TW-1:0]  tmr;
  logic [3:0]     bit_cnt;
  logic [15:0]    tx_shft;
  logic [15:0]    rx_shft;

  assign done    = (ph == SP_BACK) && (tmr == '0);
  assign rd_data = rx_shft;

  // SHIFT starts with SCLK high, so its first timeout is the front porch
  always_ff @(posedge clk) begin
    if (rst) begin
      ph      <= SP_IDLE;
      tmr     <= '0;
      bit_cnt <= '0;
      tx_shft <= '0;
      rx_shft <= '0;
      SS_n    <= 1'b1;
      SCLK    <= 1'b1;
      MOSI    <= 1'b0;
    end else begin
      case (ph)
        SP_IDLE: begin
          if (wrt) begin
            tx_shft <= wt_data;
            SS_n    <= 1'b0;
            tmr     <= TW'(PORCH - 1);
            bit_cnt <= 4'd15;
            ph      <= SP_SHIFT;
          end
        end
        SP_SHIFT: begin
          if (tmr != '0) begin
            tmr <= tmr - TW'(1);
          end else if (SCLK) begin
            SCLK    <= 1'b0;
            MOSI    <= tx_shft[15];
            tx_shft <= {tx_shft[14:0], 1'b0};
            tmr     <= TW'(HALF - 1);
          end else begin
            SCLK    <= 1'b1;
            rx_shft <= {rx_shft[14:0], MISO};
            if (bit_cnt == 4'd0) begin
              ph  <= SP_BACK;
              tmr <= TW'(PORCH - 1);
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
              tmr     <= TW'(HALF - 1);
            end
          end
        end
        SP_BACK: begin
          if (tmr != '0) begin
            tmr <= tmr - TW'(1);
          end else begin
            SS_n <= 1'b1;
            MOSI <= 1'b0;
            ph   <= SP_IDLE;
          end
        end
        default: ph <= SP_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/a2d_intf.sv
// Round-robin ADC sequencer: command transaction, one-clk gap, read transaction, then store 12-bit result.
// state | meaning
// IDLE  | waiting for nxt
// XFR1  | sending channel command word
// GAP   | one clk with SS_n high between transactions
// XFR2  | sending zeros, receiving conversion result
// DONE  | store result, pulse cnv_cmplt, advance robin
import a2d_pkg::*;

module a2d_intf #(
  parameter int SCLK_DIV = 16,
  parameter int PORCH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        busy,
  output logic        cnv_cmplt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        A2D_SS_n,
  output logic        A2D_SCLK,
  output logic        A2D_MOSI,
  input  logic        A2D_MISO
);

  a2d_state_t  state, nxt_state;
  logic [1:0]  robin;
  logic        wrt;
  logic [15:0] wt_data;
  logic        done;
  logic [15:0] rd_data;
  logic        unused_rx_hi;

  spi_mnrch #(.SCLK_DIV(SCLK_DIV), .PORCH(PORCH)) u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .wt_data (wt_data),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (A2D_SS_n),
    .SCLK    (A2D_SCLK),
    .MOSI    (A2D_MOSI),
    .MISO    (A2D_MISO)
  );

  assign unused_rx_hi = ^rd_data[15:12];
  assign busy         = (state != IDLE);
  assign cnv_cmplt    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    wrt       = 1'b0;
    wt_data   = '0;
    case (state)
      IDLE: begin
        if (nxt) begin
          wrt       = 1'b1;
          wt_data   = cmd_word(robin_chnl(robin));
          nxt_state = XFR1;
        end
      end
      XFR1: if (done) nxt_state = GAP;
      GAP: begin
        wrt       = 1'b1;
        nxt_state = XFR2;
      end
      XFR2: if (done) nxt_state = DONE;
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      robin   <= 2'd0;
      lft_ld  <= '0;
      rght_ld <= '0;
      batt    <= '0;
    end else if (state == DONE) begin
      case (robin_chnl(robin))
        CH_RGHT: rght_ld <= rd_data[11:0];
        CH_BATT: batt    <= rd_data[11:0];
        default: lft_ld  <= rd_data[11:0];
      endcase
      robin <= robin_next(robin);
    end
  end

endmodule

// File: tb/tb_a2d_intf.sv
// Directed bench for a2d_intf with a behavioral ADC that answers {4'hC, adc_val} on every transaction.
// Command words seen on MOSI are queued per transaction; cnv_cmplt pulses are counted.
module tb_a2d_intf;

  logic        clk = 1'b0;
  logic        rst, nxt;
  logic        busy, cnv_cmplt;
  logic [11:0] lft_ld, rght_ld, batt;
  logic        A2D_SS_n, A2D_SCLK, A2D_MOSI, A2D_MISO;

  int checks   = 0;
  int failures = 0;

  logic [11:0] adc_val   = 12'h000;
  logic [15:0] miso_shft = 16'h0000;
  logic [15:0] mosi_cap  = 16'h0000;
  bit          first_fall;
  logic [15:0] mosi_q[$];
  int          cmplt_cnt = 0;

  a2d_intf dut (
    .clk       (clk),
    .rst       (rst),
    .nxt       (nxt),
    .busy      (busy),
    .cnv_cmplt (cnv_cmplt),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .batt      (batt),
    .A2D_SS_n  (A2D_SS_n),
    .A2D_SCLK  (A2D_SCLK),
    .A2D_MOSI  (A2D_MOSI),
    .A2D_MISO  (A2D_MISO)
  );

  always #5 clk = ~clk;

  assign A2D_MISO = miso_shft[15];

  always @(negedge A2D_SS_n) begin
    miso_shft  = {4'hC, adc_val};
    mosi_cap   = 16'h0000;
    first_fall = 1'b1;
  end

  always @(negedge A2D_SCLK) begin
    if (!A2D_SS_n) begin
      if (first_fall) first_fall = 1'b0;
      else            miso_shft  = miso_shft << 1;
    end
  end

  always @(posedge A2D_SCLK) begin
    if (!A2D_SS_n) mosi_cap = {mosi_cap[14:0], A2D_MOSI};
  end

  always @(posedge A2D_SS_n) mosi_q.push_back(mosi_cap);

  always @(negedge clk) begin
    if (cnv_cmplt === 1'b1) cmplt_cnt++;
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clear_log();
    mosi_q.delete();
    cmplt_cnt = 0;
  endtask

  task automatic pulse_nxt();
    @(posedge clk); #1 nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
  endtask

  task automatic wait_idle(input int max_clk, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_clk; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_conv(input logic [11:0] v, output bit timed_out);
    adc_val = v;
    clear_log();
    pulse_nxt();
    wait_idle(2000, timed_out);
  endtask

  task automatic test_reset();
    do_reset();
    repeat (100) @(posedge clk);
    #1;
    checks++; if (lft_ld !== 12'h000) begin failures++; $display("FAIL reset_lft got=%h exp=000", lft_ld); end
    checks++; if (rght_ld !== 12'h000) begin failures++; $display("FAIL reset_rght got=%h exp=000", rght_ld); end
    checks++; if (batt !== 12'h000) begin failures++; $display("FAIL reset_batt got=%h exp=000", batt); end
    checks++; if (A2D_SS_n !== 1'b1) begin failures++; $display("FAIL reset_ss_n got=%b exp=1", A2D_SS_n); end
    checks++; if (A2D_SCLK !== 1'b1) begin failures++; $display("FAIL reset_sclk got=%b exp=1", A2D_SCLK); end
    checks++; if (A2D_MOSI !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", A2D_MOSI); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cnv_cmplt !== 1'b0) begin failures++; $display("FAIL reset_cmplt got=%b exp=0", cnv_cmplt); end
  endtask

  task automatic test_single();
    bit to;
    adc_val = 12'hA5C;
    clear_log();
    pulse_nxt();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    wait_idle(2000, to);
    @(posedge clk); #1;
    checks++; if (to) begin failures++; $display("FAIL single_timeout busy still high"); end
    checks++; if (mosi_q.size() !== 2) begin failures++; $display("FAIL single_xfr_cnt got=%0d exp=2", mosi_q.size()); end
    else begin
      checks++; if (mosi_q[0] !== 16'h0000) begin failures++; $display("FAIL single_cmd got=%h exp=0000", mosi_q[0]); end
      checks++; if (mosi_q[1] !== 16'h0000) begin failures++; $display("FAIL single_word2 got=%h exp=0000", mosi_q[1]); end
    end
    checks++; if (lft_ld !== 12'hA5C) begin failures++; $display("FAIL single_lft got=%h exp=a5c", lft_ld); end
    checks++; if (cmplt_cnt !== 1) begin failures++; $display("FAIL single_cmplt_cnt got=%0d exp=1", cmplt_cnt); end
  endtask

  task automatic test_round_robin();
    logic [11:0] vals[3] = '{12'h123, 12'h456, 12'hFFF};
    logic [15:0] cmds[3] = '{16'h0000, 16'h2000, 16'h2800};
    bit to;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run_conv(vals[k], to);
      checks++; if (to) begin failures++; $display("FAIL rr_timeout conv=%0d", k); end
      checks++; if (mosi_q.size() < 1 || mosi_q[0] !== cmds[k]) begin
        failures++; $display("FAIL rr_cmd conv=%0d got=%h exp=%h", k, (mosi_q.size() > 0) ? mosi_q[0] : 16'hxxxx, cmds[k]);
      end
    end
    checks++; if (lft_ld !== 12'h123) begin failures++; $display("FAIL rr_lft got=%h exp=123", lft_ld); end
    checks++; if (rght_ld !== 12'h456) begin failures++; $display("FAIL rr_rght got=%h exp=456", rght_ld); end
    checks++; if (batt !== 12'hFFF) begin failures++; $display("FAIL rr_batt got=%h exp=fff", batt); end
  endtask

  task automatic test_wrap();
    bit to;
    run_conv(12'h777, to);
    checks++; if (to) begin failures++; $display("FAIL wrap_timeout"); end
    checks++; if (mosi_q.size() < 1 || mosi_q[0] !== 16'h0000) begin failures++; $display("FAIL wrap_cmd exp=0000 size=%0d", mosi_q.size()); end
    checks++; if (lft_ld !== 12'h777) begin failures++; $display("FAIL wrap_lft got=%h exp=777", lft_ld); end
    checks++; if (rght_ld !== 12'h456) begin failures++; $display("FAIL wrap_rght got=%h exp=456", rght_ld); end
    checks++; if (batt !== 12'hFFF) begin failures++; $display("FAIL wrap_batt got=%h exp=fff", batt); end
  endtask

  task automatic test_nxt_ignored();
    bit to;
    adc_val = 12'h3C3;
    clear_log();
    pulse_nxt();
    repeat (50) @(posedge clk);
    pulse_nxt();
    wait_idle(2000, to);
    repeat (600) @(posedge clk);
    #1;
    checks++; if (to) begin failures++; $display("FAIL ign_timeout"); end
    checks++; if (cmplt_cnt !== 1) begin failures++; $display("FAIL ign_cmplt_cnt got=%0d exp=1", cmplt_cnt); end
    checks++; if (mosi_q.size() !== 2) begin failures++; $display("FAIL ign_xfr_cnt got=%0d exp=2", mosi_q.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_busy got=%b exp=0", busy); end
    checks++; if (rght_ld !== 12'h3C3) begin failures++; $display("FAIL ign_rght got=%h exp=3c3", rght_ld); end
    checks++; if (lft_ld !== 12'h777) begin failures++; $display("FAIL ign_lft got=%h exp=777", lft_ld); end
  endtask

  task automatic test_back_to_back();
    bit to, seen;
    adc_val = 12'h5A5;
    clear_log();
    pulse_nxt();
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cnv_cmplt === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL b2b_first_timeout"); end
    adc_val = 12'h0F0;
    @(posedge clk); #1 nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    wait_idle(2000, to);
    @(posedge clk); #1;
    checks++; if (to) begin failures++; $display("FAIL b2b_second_timeout"); end
    checks++; if (cmplt_cnt !== 2) begin failures++; $display("FAIL b2b_cmplt_cnt got=%0d exp=2", cmplt_cnt); end
    checks++; if (mosi_q.size() !== 4) begin failures++; $display("FAIL b2b_xfr_cnt got=%0d exp=4", mosi_q.size()); end
    else begin
      checks++; if (mosi_q[0] !== 16'h2800) begin failures++; $display("FAIL b2b_cmd1 got=%h exp=2800", mosi_q[0]); end
      checks++; if (mosi_q[2] !== 16'h0000) begin failures++; $display("FAIL b2b_cmd2 got=%h exp=0000", mosi_q[2]); end
    end
    checks++; if (batt !== 12'h5A5) begin failures++; $display("FAIL b2b_batt got=%h exp=5a5", batt); end
    checks++; if (lft_ld !== 12'h0F0) begin failures++; $display("FAIL b2b_lft got=%h exp=0f0", lft_ld); end
  endtask

  task automatic test_reset_mid();
    bit hi, lo, to;
    adc_val = 12'hBEE;
    clear_log();
    pulse_nxt();
    hi = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (A2D_SS_n === 1'b1) begin hi = 1'b1; break; end
    end
    lo = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (A2D_SS_n === 1'b0) begin lo = 1'b1; break; end
    end
    checks++; if (!(hi && lo)) begin failures++; $display("FAIL mid_reach_xfr2 hi=%b lo=%b", hi, lo); end
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (A2D_SS_n !== 1'b1) begin failures++; $display("FAIL mid_ss_n got=%b exp=1", A2D_SS_n); end
    checks++; if (A2D_SCLK !== 1'b1) begin failures++; $display("FAIL mid_sclk got=%b exp=1", A2D_SCLK); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if ({lft_ld, rght_ld, batt} !== 36'h0) begin
      failures++; $display("FAIL mid_results got=%h/%h/%h exp=0/0/0", lft_ld, rght_ld, batt);
    end
    rst = 1'b0;
    run_conv(12'h0AB, to);
    checks++; if (to) begin failures++; $display("FAIL mid_timeout"); end
    checks++; if (mosi_q.size() < 1 || mosi_q[0] !== 16'h0000) begin failures++; $display("FAIL mid_robin_cmd exp=0000 size=%0d", mosi_q.size()); end
    checks++; if (lft_ld !== 12'h0AB) begin failures++; $display("FAIL mid_lft got=%h exp=0ab", lft_ld); end
    checks++; if (rght_ld !== 12'h000) begin failures++; $display("FAIL mid_rght got=%h exp=000", rght_ld); end
  endtask

  initial begin
    rst = 1'b1;
    nxt = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_nxt_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
